// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and defaults for the data-memory store buffer
package mips_mem_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] addr;
        logic [DEF_WIDTH-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// rtl/sb_match.sv - address CAM over the store-buffer entries, one-hot hit plus index
module sb_match #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int IW    = $clog2(DEPTH)
) (
    input  logic [WIDTH-1:0]            addr,
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][WIDTH-1:0] entry_addr,
    output logic [DEPTH-1:0]            hit_vec,
    output logic [IW-1:0]               hit_idx
);

    // Coalescing keeps addresses unique, so at most one bit of hit_vec is set.
    always_comb begin
        hit_vec = '0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid[i] && (entry_addr[i] == addr);
            if (hit_vec[i]) begin
                hit_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// rtl/dmem_store_buffer.sv - coalescing posted-write buffer with load forwarding and flush
module dmem_store_buffer
    import mips_mem_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int DRAIN_TH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             core_we,
    input  logic             core_re,
    input  logic [WIDTH-1:0] core_addr,
    input  logic [WIDTH-1:0] core_wd,
    output logic [WIDTH-1:0] core_rd,
    output logic             core_stall,
    input  logic             flush_req,
    output logic             flush_done,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0][WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;
    logic [IW-1:0]               head_q;
    logic [IW-1:0]               tail_q;
    logic [CW-1:0]               count_q;
    logic [CW-1:0]               count_d;
    sb_state_e                   state_q;
    sb_state_e                   state_d;

    logic             in_flush;
    logic             st_we;
    logic             ld_re;
    logic [DEPTH-1:0] hit_vec;
    logic [IW-1:0]    hit_idx;
    logic             hit;
    logic             empty;
    logic             full;
    logic             store_hit;
    logic             store_miss;
    logic             drain;
    logic             head_fresh;

    sb_match #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_match (
        .addr       (core_addr),
        .valid      (valid_q),
        .entry_addr (addr_q),
        .hit_vec    (hit_vec),
        .hit_idx    (hit_idx)
    );

    // Core requests are dropped while the flush owns the buffer.
    assign in_flush   = (state_q == FLUSH);
    assign st_we      = core_we && !in_flush;
    assign ld_re      = core_re && !in_flush;
    assign hit        = |hit_vec;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign store_hit  = st_we && hit;
    assign store_miss = st_we && !hit;
    assign head_fresh = store_hit && (hit_idx == head_q);

    // A load always owns the memory port; otherwise drain when any pressure exists.
    assign drain = !ld_re && !empty &&
                   ((count_q >= CW'(DRAIN_TH)) || !st_we || in_flush || (store_miss && full));

    assign count_d = count_q + CW'(store_miss) - CW'(drain);

    always_comb begin
        mem_we  = drain;
        mem_a   = '0;
        mem_wd  = '0;
        core_rd = mem_rd;
        if (ld_re) begin
            mem_a = core_addr;
            if (hit) begin
                core_rd = data_q[hit_idx];
            end
        end else if (drain) begin
            mem_a  = addr_q[head_q];
            mem_wd = head_fresh ? core_wd : data_q[head_q];
        end
    end

    // Enqueue follows retire so a full-buffer miss can reuse the slot just drained.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (drain) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + IW'(1);
            end
            if (store_hit) begin
                data_q[hit_idx] <= core_wd;
            end
            if (store_miss) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= core_addr;
                data_q[tail_q]  <= core_wd;
                tail_q          <= tail_q + IW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = empty ? DONE : FLUSH;
                end
            end
            FLUSH: begin
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!flush_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        core_stall = (state_q == FLUSH);
        flush_done = (state_q == DONE) || ((state_q == IDLE) && empty);
    end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb/tb_dmem_store_buffer.sv - directed vector bench for dmem_store_buffer with a memory model
module tb_dmem_store_buffer;

    logic        CLK;
    logic        RST;
    logic        core_we;
    logic        core_re;
    logic [31:0] core_addr;
    logic [31:0] core_wd;
    logic [31:0] core_rd;
    logic        core_stall;
    logic        flush_req;
    logic        flush_done;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int total;
    int bad;

    logic [31:0] mem [256];

    dmem_store_buffer #(
        .WIDTH    (32),
        .DEPTH    (4),
        .DRAIN_TH (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .core_we    (core_we),
        .core_re    (core_re),
        .core_addr  (core_addr),
        .core_wd    (core_wd),
        .core_rd    (core_rd),
        .core_stall (core_stall),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
        end else if (mem_we) begin
            mem[mem_a[7:0]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_a[7:0]];

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mwe;
        logic [31:0] ma;
        logic [31:0] mwd;
        logic        done;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wd, input logic fl);
        @(negedge CLK);
        core_we   = we;
        core_re   = re;
        core_addr = addr;
        core_wd   = wd;
        flush_req = fl;
        #1;
    endtask

    task automatic set_vec(input int i, input logic we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd, input logic mwe,
                           input logic [31:0] ma, input logic [31:0] mwd, input logic done);
        vt[i].we = we;   vt[i].re = re;   vt[i].addr = addr; vt[i].wd = wd;
        vt[i].rd = rd;   vt[i].mwe = mwe; vt[i].ma = ma;     vt[i].mwd = mwd;
        vt[i].done = done;
    endtask

    initial begin
        int stalls;
        bit reached;
        total = 0;
        bad   = 0;

        // forwarding, coalescing and background drain on an empty memory
        set_vec(0,  0, 0, 32'd0, 32'h0,  32'h0,  0, 32'd0, 32'h0,  1);
        set_vec(1,  1, 0, 32'd5, 32'h11, 32'h0,  0, 32'd0, 32'h0,  1);
        set_vec(2,  0, 1, 32'd5, 32'h0,  32'h11, 0, 32'd5, 32'h0,  0);
        set_vec(3,  1, 0, 32'd7, 32'hA,  32'h0,  0, 32'd0, 32'h0,  0);
        set_vec(4,  1, 0, 32'd7, 32'hB,  32'h0,  0, 32'd0, 32'h0,  0);
        set_vec(5,  0, 1, 32'd7, 32'h0,  32'hB,  0, 32'd7, 32'h0,  0);
        set_vec(6,  0, 1, 32'd3, 32'h0,  32'h0,  0, 32'd3, 32'h0,  0);
        set_vec(7,  0, 0, 32'd0, 32'h0,  32'h0,  1, 32'd5, 32'h11, 0);
        set_vec(8,  0, 1, 32'd5, 32'h0,  32'h11, 0, 32'd5, 32'h0,  0);
        set_vec(9,  0, 0, 32'd0, 32'h0,  32'h0,  1, 32'd7, 32'hB,  0);
        set_vec(10, 0, 1, 32'd7, 32'h0,  32'hB,  0, 32'd7, 32'h0,  1);
        set_vec(11, 0, 0, 32'd0, 32'h0,  32'h0,  0, 32'd0, 32'h0,  1);

        RST = 1'b0;
        core_we = 0; core_re = 0; core_addr = 0; core_wd = 0; flush_req = 0;
        #1;
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        chk("rst_stall", 32'(core_stall), 32'h0);
        chk("rst_done", 32'(flush_done), 32'h1);
        chk("rst_rd", core_rd, mem_rd);
        @(negedge CLK);
        RST = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].we, vt[i].re, vt[i].addr, vt[i].wd, 1'b0);
            chk($sformatf("v%0d_rd", i), core_rd, vt[i].rd);
            chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vt[i].mwe));
            chk($sformatf("v%0d_mem_a", i), mem_a, vt[i].ma);
            chk($sformatf("v%0d_mem_wd", i), mem_wd, vt[i].mwd);
            chk($sformatf("v%0d_done", i), 32'(flush_done), 32'(vt[i].done));
            chk($sformatf("v%0d_stall", i), 32'(core_stall), 32'h0);
        end

        // fill to DEPTH, then a miss while full drains the head in the same cycle
        for (int a = 1; a <= 4; a++) begin
            drive(1, 0, 32'(a), 32'h100 + 32'(a), 0);
            chk($sformatf("fill%0d_mem_we", a), 32'(mem_we), 32'h0);
        end
        drive(1, 0, 32'd9, 32'h109, 0);
        chk("fullmiss_mem_we", 32'(mem_we), 32'h1);
        chk("fullmiss_mem_a", mem_a, 32'd1);
        chk("fullmiss_mem_wd", mem_wd, 32'h101);
        chk("fullmiss_stall", 32'(core_stall), 32'h0);
        // store hit on the head while draining writes the fresh data
        drive(1, 0, 32'd2, 32'h222, 0);
        chk("headhit_mem_we", 32'(mem_we), 32'h1);
        chk("headhit_mem_a", mem_a, 32'd2);
        chk("headhit_mem_wd", mem_wd, 32'h222);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 32'd100 + 32'(k), 0, 0);
            chk($sformatf("ldprio%0d_mem_we", k), 32'(mem_we), 32'h0);
            chk($sformatf("ldprio%0d_mem_a", k), mem_a, 32'd100 + 32'(k));
        end
        drive(0, 0, 0, 0, 0);
        chk("resume0_mem_a", mem_a, 32'd3);
        chk("resume0_mem_wd", mem_wd, 32'h103);
        chk("resume0_mem_we", 32'(mem_we), 32'h1);
        drive(0, 0, 0, 0, 0);
        chk("resume1_mem_a", mem_a, 32'd4);
        chk("resume1_mem_wd", mem_wd, 32'h104);
        drive(0, 0, 0, 0, 0);
        chk("resume2_mem_a", mem_a, 32'd9);
        chk("resume2_mem_wd", mem_wd, 32'h109);
        drive(0, 0, 0, 0, 0);
        chk("empty_mem_we", 32'(mem_we), 32'h0);
        chk("empty_done", 32'(flush_done), 32'h1);
        drive(0, 1, 32'd2, 0, 0);
        chk("headhit_mem_rd", core_rd, 32'h222);
        chk("mem1", mem[1], 32'h101);

        // flush: third store coincides with the request, then three stalled drain cycles
        drive(1, 0, 32'd0, 32'hA0, 0);
        drive(1, 0, 32'd1, 32'hA1, 0);
        drive(1, 0, 32'd2, 32'hA2, 1);
        chk("flush_entry_stall", 32'(core_stall), 32'h0);
        stalls  = 0;
        reached = 0;
        for (int c = 0; c < 10 && !reached; c++) begin
            drive(0, 0, 0, 0, 1);
            if (flush_done) reached = 1;
            else if (core_stall) stalls++;
        end
        chk("flush_reached_done", 32'(reached), 32'h1);
        chk("flush_stall_cycles", 32'(stalls), 32'd3);
        chk("flush_done_stall", 32'(core_stall), 32'h0);
        chk("flush_mem0", mem[0], 32'hA0);
        chk("flush_mem1", mem[1], 32'hA1);
        chk("flush_mem2", mem[2], 32'hA2);
        drive(0, 0, 0, 0, 0);
        chk("flush_release_done", 32'(flush_done), 32'h1);
        drive(0, 0, 0, 0, 0);
        chk("flush_idle_done", 32'(flush_done), 32'h1);
        chk("flush_idle_mem_we", 32'(mem_we), 32'h0);

        // reset asserted in the middle of a flush
        drive(1, 0, 32'd20, 32'h20, 0);
        drive(1, 0, 32'd21, 32'h21, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        chk("midflush_stall", 32'(core_stall), 32'h1);
        RST = 1'b0;
        #1;
        chk("midrst_stall", 32'(core_stall), 32'h0);
        chk("midrst_done", 32'(flush_done), 32'h1);
        chk("midrst_mem_we", 32'(mem_we), 32'h0);
        chk("midrst_mem_a", mem_a, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk("postrst_mem_we", 32'(mem_we), 32'h0);
        chk("postrst_done", 32'(flush_done), 32'h1);
        chk("postrst_mem21", mem[21], 32'h0);
        drive(0, 1, 32'd21, 0, 0);
        chk("postrst_ld21", core_rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
